afe_timing_gen: RTL and testbench
=================================

AFE_TIMING_GEN -- requirements
Module: afe_timing_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of delayed VSMP output channels (1..8).
REQ-002 Parameter DLY_W, default 8: width of each per-channel delay field, in clk ticks.
REQ-003 Parameter PER_W, default 16: width of pixel-period and RSMP-position fields.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 run  in  1  level; 1 = generate timing, 0 = stop at the end of the current pixel.
REQ-007 cfg_wr  in  1  one-cycle strobe; captures all cfg_* inputs into the shadow set.
REQ-008 cfg_period  in  PER_W  pixel period in ticks (legal 4..2^PER_W-1).
REQ-009 cfg_vsmp_w / cfg_rsmp_w  in  8 each  VSMP / RSMP high width in ticks (0 = never high).
REQ-010 cfg_rsmp_pos  in  PER_W  RSMP rising tick within the pixel.
REQ-011 cfg_mclk_half  in  8  MCLK half-period in ticks (0 treated as 1).
REQ-012 cfg_dly  in  NUM_CH*DLY_W  per-channel VSMP delay, channel 0 in the LSBs.
REQ-013 mclk, rsmp  out  1 each; vsmp  out  NUM_CH; all registered.
REQ-014 pix_strobe  out  1  one-tick pulse on pixel counter tick 0.
REQ-015 busy  out  1; cfg_pending  out  1; cfg_err  out  NUM_CH, sticky per-channel delay error.

Function
REQ-016 States: IDLE, RUN, DRAIN; IDLE->RUN when run=1; RUN->DRAIN when run=0; DRAIN->IDLE on the last tick of the pixel (pcnt = period-1); DRAIN->RUN when run=1 returns before that tick.
REQ-017 Pixel counter pcnt counts 0..period-1 and wraps in RUN/DRAIN; held at 0 in IDLE; busy=1 in RUN and DRAIN.
REQ-018 Active config is loaded from shadow only when pcnt wraps to 0 or on IDLE->RUN; a mid-pixel cfg_wr never changes the current pixel.
REQ-019 cfg_pending is set by cfg_wr and cleared on the load cycle; cfg_wr on the load cycle itself is captured and applied on the next boundary.
REQ-020 Base VSMP = (pcnt < vsmp_w); rsmp = (pcnt >= rsmp_pos) and (pcnt < rsmp_pos+rsmp_w), compared at PER_W+1 bits, with no wrap into the next pixel.
REQ-021 MCLK counter restarts at pcnt=0 with mclk=1 and toggles every mclk_half ticks.
REQ-022 Channel k: on each base-VSMP rising edge, load down-counter with dly[k]; when it reaches 0, vsmp[k] goes high for vsmp_w ticks; dly[k]=0 means vsmp[k] equals base VSMP.
REQ-023 If dly[k]+vsmp_w >= period, vsmp[k] is held low for that pixel and cfg_err[k] is set; cfg_err is cleared only by rst.
REQ-024 A base-VSMP rising edge while channel k is still counting restarts its counter; the earlier pulse is dropped.
REQ-025 All outputs have a fixed 1-tick latency from pcnt; mclk, rsmp and vsmp are 0 in IDLE.

Reset
REQ-026 On rst: state IDLE, pcnt=0, all outputs 0, cfg_err=0, cfg_pending=0; shadow and active config = period 16, vsmp_w 2, rsmp_pos 8, rsmp_w 2, mclk_half 2, all delays 0.
REQ-027 rst asserted mid-pixel forces reset values on the next edge, and no pulse is completed.

Configuration
REQ-028 Macro AFE_TIMING_DLY_EN defined: per-channel delay per REQ-022..024.
REQ-029 Macro AFE_TIMING_DLY_EN undefined: cfg_dly is ignored, every vsmp[k] equals base VSMP, cfg_err is tied to 0, and no delay counters are built.

Structure
REQ-030 Package afe_timing_pkg holds the state encoding, reset-default constants and the NUM_CH maximum.
REQ-031 Sub-module afe_chan_delay implements one channel's delay counter and pulse generator, instantiated NUM_CH times in a generate loop.

Verification
REQ-032 Defaults, run=1: pix_strobe every 16 ticks, vsmp high at ticks 0-1, rsmp at ticks 8-9, mclk period 4 ticks.
REQ-033 cfg_wr of period=20 at tick 5: current pixel stays 16 ticks, cfg_pending=1 until the wrap, next pixel is 20 ticks.
REQ-034 dly = {0,3,7,15}, period 16, vsmp_w 2: vsmp[0..2] rise at ticks 0/3/7; vsmp[3] stays low and cfg_err[3]=1.
REQ-035 run dropped at tick 4: outputs continue to tick 15, then IDLE with busy=0 and all outputs 0.
REQ-036 rst asserted at tick 9 during rsmp high: next edge gives rsmp=0, pcnt=0, config reverts to defaults.

Source files
------------

// File: rtl/afe_timing_pkg.sv
// rtl/afe_timing_pkg.sv - shared state encoding, reset defaults and limits for afe_timing_gen
package afe_timing_pkg;

  localparam int NUM_CH_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } afe_state_t;

  localparam int DEF_PERIOD    = 16;
  localparam int DEF_VSMP_W    = 2;
  localparam int DEF_RSMP_POS  = 8;
  localparam int DEF_RSMP_W    = 2;
  localparam int DEF_MCLK_HALF = 2;

endpackage

// File: rtl/afe_chan_delay.sv
// rtl/afe_chan_delay.sv - one VSMP channel: delay down-counter, pulse stretcher and sticky error
module afe_chan_delay #(
  parameter int DLY_W = 8,
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             rise,
  input  logic             base_v,
  input  logic [DLY_W-1:0] dly,
  input  logic [7:0]       vsmp_w,
  input  logic [PER_W-1:0] period,
  output logic             vsmp,
  output logic             err
);

  localparam int AW = (DLY_W > 8) ? DLY_W : 8;
  localparam int SW = ((AW > PER_W) ? AW : PER_W) + 1;

  logic [DLY_W-1:0] cnt;
  logic [7:0]       rem;
  logic             counting;
  logic             pulse_on;
  logic             fire;
  logic             err_cond;

  // A delayed pulse that would spill past the pixel end is suppressed for the whole pixel.
  assign err_cond = (SW'(dly) + SW'(vsmp_w)) >= SW'(period);
  assign fire     = counting && (cnt == '0) && (vsmp_w != 8'd0);
  assign vsmp     = !err_cond && ((dly == '0) ? base_v : (fire || pulse_on));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      counting <= 1'b0;
      pulse_on <= 1'b0;
      err      <= 1'b0;
    end else if (!active) begin
      counting <= 1'b0;
      pulse_on <= 1'b0;
    end else if (rise) begin
      // A new base edge restarts the channel and drops any pulse in flight.
      pulse_on <= 1'b0;
      counting <= (dly != '0) && !err_cond;
      cnt      <= dly - DLY_W'(1);
      if (err_cond) err <= 1'b1;
    end else if (counting) begin
      if (cnt == '0) begin
        counting <= 1'b0;
        pulse_on <= (vsmp_w > 8'd1);
        rem      <= vsmp_w - 8'd1;
      end else begin
        cnt <= cnt - DLY_W'(1);
      end
    end else if (pulse_on) begin
      pulse_on <= (rem > 8'd1);
      rem      <= rem - 8'd1;
    end
  end

endmodule

// File: rtl/afe_timing_gen.sv
// rtl/afe_timing_gen.sv - AFE pixel timing generator; AFE_TIMING_DLY_EN enables per-channel VSMP delay
module afe_timing_gen #(
  parameter int NUM_CH = 4,
  parameter int DLY_W  = 8,
  parameter int PER_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    cfg_wr,
  input  logic [PER_W-1:0]        cfg_period,
  input  logic [7:0]              cfg_vsmp_w,
  input  logic [7:0]              cfg_rsmp_w,
  input  logic [PER_W-1:0]        cfg_rsmp_pos,
  input  logic [7:0]              cfg_mclk_half,
  input  logic [NUM_CH*DLY_W-1:0] cfg_dly,
  output logic                    mclk,
  output logic                    rsmp,
  output logic [NUM_CH-1:0]       vsmp,
  output logic                    pix_strobe,
  output logic                    busy,
  output logic                    cfg_pending,
  output logic [NUM_CH-1:0]       cfg_err
);

  import afe_timing_pkg::*;

  localparam int CW = ((PER_W > 8) ? PER_W : 8) + 1;

  afe_state_t       state, state_nxt;
  logic [PER_W-1:0] pcnt, pcnt_nxt;
  logic             last, load, running;

  logic [PER_W-1:0] shd_period, act_period, shd_rsmp_pos, act_rsmp_pos;
  logic [7:0]       shd_vsmp_w, act_vsmp_w, shd_rsmp_w, act_rsmp_w;
  logic [7:0]       shd_mclk_half, act_mclk_half;

  logic [7:0]        m_cnt, half_eff;
  logic              m_lvl;
  logic              base_v, base_prev, rise, rsmp_c, strobe_c, mclk_c;
  logic [NUM_CH-1:0] vsmp_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
    end
  end

  assign last = (pcnt == act_period - PER_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (run) state_nxt = ST_RUN;
      ST_RUN,
      ST_DRAIN: begin
        if (run)       state_nxt = ST_RUN;
        else if (last) state_nxt = ST_IDLE;
        else           state_nxt = ST_DRAIN;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Config changes only take effect at a pixel boundary or when leaving IDLE.
  assign load     = ((state == ST_IDLE) && run) ||
                    ((state != ST_IDLE) && (state_nxt != ST_IDLE) && last);
  assign pcnt_nxt = ((state == ST_IDLE) || (state_nxt == ST_IDLE) || last) ?
                    '0 : pcnt + PER_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      shd_period    <= PER_W'(DEF_PERIOD);
      shd_vsmp_w    <= 8'(DEF_VSMP_W);
      shd_rsmp_pos  <= PER_W'(DEF_RSMP_POS);
      shd_rsmp_w    <= 8'(DEF_RSMP_W);
      shd_mclk_half <= 8'(DEF_MCLK_HALF);
      act_period    <= PER_W'(DEF_PERIOD);
      act_vsmp_w    <= 8'(DEF_VSMP_W);
      act_rsmp_pos  <= PER_W'(DEF_RSMP_POS);
      act_rsmp_w    <= 8'(DEF_RSMP_W);
      act_mclk_half <= 8'(DEF_MCLK_HALF);
      cfg_pending   <= 1'b0;
    end else begin
      if (cfg_wr) begin
        shd_period    <= cfg_period;
        shd_vsmp_w    <= cfg_vsmp_w;
        shd_rsmp_pos  <= cfg_rsmp_pos;
        shd_rsmp_w    <= cfg_rsmp_w;
        shd_mclk_half <= cfg_mclk_half;
      end
      if (load) begin
        act_period    <= shd_period;
        act_vsmp_w    <= shd_vsmp_w;
        act_rsmp_pos  <= shd_rsmp_pos;
        act_rsmp_w    <= shd_rsmp_w;
        act_mclk_half <= shd_mclk_half;
      end
      cfg_pending <= cfg_wr || (cfg_pending && !load);
    end
  end

  assign half_eff = (act_mclk_half == 8'd0) ? 8'd1 : act_mclk_half;

  always_comb begin
    running  = (state != ST_IDLE);
    base_v   = running && (CW'(pcnt) < CW'(act_vsmp_w));
    rsmp_c   = running && (CW'(pcnt) >= CW'(act_rsmp_pos)) &&
               (CW'(pcnt) < CW'(act_rsmp_pos) + CW'(act_rsmp_w));
    strobe_c = running && (pcnt == '0);
    mclk_c   = running && m_lvl;
  end

  assign rise = base_v && !base_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      mclk       <= 1'b0;
      rsmp       <= 1'b0;
      vsmp       <= '0;
      pix_strobe <= 1'b0;
      busy       <= 1'b0;
      base_prev  <= 1'b0;
      m_cnt      <= '0;
      m_lvl      <= 1'b1;
    end else begin
      mclk       <= mclk_c;
      rsmp       <= rsmp_c;
      vsmp       <= vsmp_c;
      pix_strobe <= strobe_c;
      busy       <= running;
      base_prev  <= base_v;
      // m_cnt/m_lvl describe the tick pcnt is on; every pixel starts high.
      if (pcnt_nxt == '0) begin
        m_cnt <= '0;
        m_lvl <= 1'b1;
      end else if (m_cnt == half_eff - 8'd1) begin
        m_cnt <= '0;
        m_lvl <= !m_lvl;
      end else begin
        m_cnt <= m_cnt + 8'd1;
      end
    end
  end

`ifdef AFE_TIMING_DLY_EN
  logic [NUM_CH*DLY_W-1:0] shd_dly, act_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      shd_dly <= '0;
      act_dly <= '0;
    end else begin
      if (cfg_wr) shd_dly <= cfg_dly;
      if (load)   act_dly <= shd_dly;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    afe_chan_delay #(
      .DLY_W (DLY_W),
      .PER_W (PER_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .active (running),
      .rise   (rise),
      .base_v (base_v),
      .dly    (act_dly[k*DLY_W +: DLY_W]),
      .vsmp_w (act_vsmp_w),
      .period (act_period),
      .vsmp   (vsmp_c[k]),
      .err    (cfg_err[k])
    );
  end
`else
  logic dly_unused;
  assign dly_unused = ^cfg_dly;
  assign vsmp_c     = {NUM_CH{base_v}};
  assign cfg_err    = '0;
`endif

endmodule

// File: tb/tb_afe_timing_gen.sv
// tb/tb_afe_timing_gen.sv - scoreboard bench for afe_timing_gen
`timescale 1ns/1ps
module tb_afe_timing_gen;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int PW = 16;
  localparam int OW = 5 + 2*NC;
`ifdef AFE_TIMING_DLY_EN
  localparam bit DLY_EN = 1'b1;
`else
  localparam bit DLY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, run, cfg_wr;
  logic [PW-1:0]    cfg_period, cfg_rsmp_pos;
  logic [7:0]       cfg_vsmp_w, cfg_rsmp_w, cfg_mclk_half;
  logic [NC*DW-1:0] cfg_dly;
  logic             mclk, rsmp, pix_strobe, busy, cfg_pending;
  logic [NC-1:0]    vsmp, cfg_err;

  always #5 clk = ~clk;

  afe_timing_gen #(.NUM_CH(NC), .DLY_W(DW), .PER_W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .cfg_wr        (cfg_wr),
    .cfg_period    (cfg_period),
    .cfg_vsmp_w    (cfg_vsmp_w),
    .cfg_rsmp_w    (cfg_rsmp_w),
    .cfg_rsmp_pos  (cfg_rsmp_pos),
    .cfg_mclk_half (cfg_mclk_half),
    .cfg_dly       (cfg_dly),
    .mclk          (mclk),
    .rsmp          (rsmp),
    .vsmp          (vsmp),
    .pix_strobe    (pix_strobe),
    .busy          (busy),
    .cfg_pending   (cfg_pending),
    .cfg_err       (cfg_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wcyc;
  logic [OW-1:0] sb_q[$];
  int strobes[$];

  int m_st, m_p, m_pend;
  int a_per, a_vw, a_rp, a_rw, a_mh;
  int s_per, s_vw, s_rp, s_rw, s_mh;
  int a_d[NC];
  int s_d[NC];
  bit [NC-1:0] m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_p = 0; m_pend = 0; m_err = '0;
    a_per = 16; a_vw = 2; a_rp = 8; a_rw = 2; a_mh = 2;
    s_per = 16; s_vw = 2; s_rp = 8; s_rw = 2; s_mh = 2;
    for (int k = 0; k < NC; k++) begin
      a_d[k] = 0;
      s_d[k] = 0;
    end
  endtask

  task automatic step();
    logic [OW-1:0] e, got;
    logic [NC-1:0] vs;
    int h, d, nst;
    bit busy_e, cond, lastp, load, rs, mc, st;
    if (rst) begin
      m_reset();
      e = '0;
    end else begin
      busy_e = (m_st != 0);
      h  = (a_mh == 0) ? 1 : a_mh;
      mc = busy_e && ((m_p / h) % 2 == 0);
      rs = busy_e && (m_p >= a_rp) && (m_p < a_rp + a_rw);
      st = busy_e && (m_p == 0);
      for (int k = 0; k < NC; k++) begin
        d     = DLY_EN ? a_d[k] : 0;
        cond  = DLY_EN && (d + a_vw >= a_per);
        vs[k] = busy_e && !cond && (m_p >= d) && (m_p < d + a_vw);
        if (busy_e && cond && m_p == 0 && a_vw > 0) m_err[k] = 1'b1;
      end
      lastp = (m_p == a_per - 1);
      if (m_st == 0) nst = run ? 1 : 0;
      else           nst = run ? 1 : (lastp ? 0 : 2);
      load = (m_st == 0 && run) || (m_st != 0 && nst != 0 && lastp);
      m_pend = (cfg_wr || (m_pend != 0 && !load)) ? 1 : 0;
      if (load) begin
        a_per = s_per; a_vw = s_vw; a_rp = s_rp; a_rw = s_rw; a_mh = s_mh;
        for (int k = 0; k < NC; k++) a_d[k] = s_d[k];
      end
      if (cfg_wr) begin
        s_per = cfg_period; s_vw = cfg_vsmp_w; s_rp = cfg_rsmp_pos;
        s_rw = cfg_rsmp_w; s_mh = cfg_mclk_half;
        for (int k = 0; k < NC; k++) s_d[k] = cfg_dly[k*DW +: DW];
      end
      m_p  = (m_st == 0 || nst == 0 || lastp) ? 0 : m_p + 1;
      m_st = nst;
      e = {busy_e, m_pend[0], st, mc, rs, vs, m_err};
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = {busy, cfg_pending, pix_strobe, mclk, rsmp, vsmp, cfg_err};
    if (pix_strobe) strobes.push_back(cyc);
    check_eq("out", 32'(got), 32'(sb_q.pop_front()));
  endtask

  task automatic wait_p(input int target);
    for (int i = 0; i < 200 && !(m_st != 0 && m_p == target); i++) step();
    check_eq("wait_p", 32'(m_p), 32'(target));
  endtask

  task automatic rand_cfg();
    int per;
    per           = $urandom_range(40, 4);
    cfg_period    = PW'(per);
    cfg_vsmp_w    = 8'($urandom_range(per - 1, 0));
    cfg_rsmp_pos  = PW'($urandom_range(45, 0));
    cfg_rsmp_w    = 8'($urandom_range(20, 0));
    cfg_mclk_half = 8'($urandom_range(5, 0));
    for (int k = 0; k < NC; k++) cfg_dly[k*DW +: DW] = DW'($urandom_range(per, 0));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; cfg_wr = 1'b0;
    cfg_period = 16; cfg_vsmp_w = 2; cfg_rsmp_pos = 8; cfg_rsmp_w = 2;
    cfg_mclk_half = 2; cfg_dly = '0;
    step(); step();
    rst = 1'b0;
    step();

    // defaults, free running
    run = 1'b1;
    repeat (40) step();

    // mid-pixel period change to 20
    wait_p(5);
    cfg_period = 20; cfg_wr = 1'b1;
    strobes.delete();
    step();
    wcyc = cyc;
    cfg_wr = 1'b0;
    repeat (45) step();
    check_eq("strobe_cnt", 32'(strobes.size() >= 2), 32'd1);
    if (strobes.size() >= 2) begin
      check_eq("cur_pixel_len", 32'(strobes[0] - wcyc), 32'd11);
      check_eq("next_pixel_len", 32'(strobes[1] - strobes[0]), 32'd20);
    end

    // per-channel delays 0/3/7/15
    wait_p(2);
    cfg_period = 16; cfg_vsmp_w = 2; cfg_dly = {8'd15, 8'd7, 8'd3, 8'd0};
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    repeat (40) step();
    check_eq("err_sticky", 32'(cfg_err), DLY_EN ? 32'h8 : 32'h0);

    // run dropped mid-pixel
    wait_p(4);
    run = 1'b0;
    repeat (20) step();
    check_eq("idle_outs", 32'({busy, mclk, rsmp, vsmp, pix_strobe}), 32'd0);

    // short period, mclk_half 0, rsmp clipped at pixel end, drain then resume
    cfg_period = 10; cfg_vsmp_w = 3; cfg_rsmp_pos = 7; cfg_rsmp_w = 5;
    cfg_mclk_half = 0; cfg_dly = {8'd6, 8'd2, 8'd1, 8'd0};
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    run = 1'b1;
    repeat (25) step();
    wait_p(2);
    run = 1'b0;
    repeat (3) step();
    run = 1'b1;
    repeat (30) step();

    // random configs and run toggling
    repeat (400) begin
      if ($urandom_range(15, 0) == 0) begin
        rand_cfg();
        cfg_wr = 1'b1;
      end
      if ($urandom_range(29, 0) == 0) run = ~run;
      step();
      cfg_wr = 1'b0;
    end

    // reset during rsmp high
    rst = 1'b1;
    step();
    rst = 1'b0;
    run = 1'b1;
    wait_p(9);
    check_eq("rsmp_before_rst", 32'(rsmp), 32'd1);
    rst = 1'b1;
    step();
    check_eq("rsmp_after_rst", 32'(rsmp), 32'd0);
    rst = 1'b0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
